// File: rtl/r5p_tcb_arb2_pkg.sv
// Shared types and constants for the two-manager TCB arbiter.
package r5p_tcb_arb2_pkg;

  // Number of managers merged onto the subordinate port.
  localparam int TCB_ARB_MAN = 2;

  // Response routing tag: one entry per cycle of subordinate response delay.
  typedef struct packed {
    logic       vld;  // a transfer happened in the cycle this tag was loaded
    logic [0:0] id;   // manager index that owned that transfer
  } tcb_arb_tag_t;

  // Lock state: FREE arbitrates every cycle, LOCK holds the grant while the
  // subordinate stalls a pending request.
  typedef enum logic {
    ST_FREE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/r5p_tcb_arb2_if.sv
// TCB bus bundle: request fields from manager, ready/response from subordinate.
interface r5p_tcb_arb2_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = DW/8
) ();

  // Handshake: a transfer happens in any cycle where vld & rdy are both 1;
  // the manager holds vld and all request fields stable until that cycle,
  // and the response (rdt/err) appears a fixed DLY cycles after it.
  logic          vld;
  logic          wen;
  logic [AW-1:0] adr;
  logic [BW-1:0] ben;
  logic [DW-1:0] wdt;
  logic          rdy;
  logic [DW-1:0] rdt;
  logic          err;

  modport master (
    output vld, wen, adr, ben, wdt,
    input  rdy, rdt, err
  );

  modport slave (
    input  vld, wen, adr, ben, wdt,
    output rdy, rdt, err
  );

endinterface

// File: rtl/r5p_tcb_arb2_rte.sv
// Response routing tag pipeline: delays the {transfer, grant} tag by DLY
// cycles so each response is steered to the manager that issued it.
module r5p_tcb_arb_rte
  import r5p_tcb_arb2_pkg::*;
#(
  parameter int DLY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  tcb_arb_tag_t i_tag,
  output tcb_arb_tag_t o_tag
);

  generate
    if (DLY == 0) begin : g_bypass
      // Combinational subordinate: the current request owns the response.
      wire w_unused_clk_rst = clk | rst;
      assign o_tag = i_tag;
    end else begin : g_pipe
      tcb_arb_tag_t r_rte [DLY];

      // Shift a new tag in every cycle; reset drops all in-flight tags.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DLY; i++) r_rte[i] <= '0;
        end else begin
          r_rte[0] <= i_tag;
          for (int i = 1; i < DLY; i++) r_rte[i] <= r_rte[i-1];
        end
      end

      assign o_tag = r_rte[DLY-1];
    end
  endgenerate

endmodule

// File: rtl/r5p_tcb_arb2.sv
// Two-manager to one-subordinate TCB arbiter: IFU (m0) and LSU (m1) onto one
// memory port. LSU has fixed priority, IFU starvation is bounded by STV, and
// the grant is locked while the subordinate stalls a pending request.
module r5p_tcb_arb2
  import r5p_tcb_arb2_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = DW/8,
  parameter int DLY = 1,
  parameter int STV = 4
) (
  input  logic       clk,
  input  logic       rst,
  r5p_tcb_arb2_if.slave  m0,
  r5p_tcb_arb2_if.slave  m1,
  r5p_tcb_arb2_if.master s,
  output logic       o_lck,
  output logic       o_lgnt,
  output logic [3:0] o_scnt
);

  localparam logic [3:0] STV_C = 4'(STV);

  arb_state_t    r_state;
  logic          r_lgnt;
  logic [3:0]    r_scnt;

  logic          w_gnt;
  logic          w_vld;
  logic          w_xfer;
  logic          w_wen;
  logic [AW-1:0] w_adr;
  logic [BW-1:0] w_ben;
  logic [DW-1:0] w_wdt;
  tcb_arb_tag_t  w_tag_in;
  tcb_arb_tag_t  w_own;

  // Grant selection from registered lock/counter state.
  always_comb begin
    w_gnt = 1'b0;
    if (r_state == ST_LOCK) begin
      w_gnt = r_lgnt;
    end else if (m0.vld && m1.vld) begin
      w_gnt = (r_scnt == STV_C) ? 1'b0 : 1'b1;
    end else begin
      w_gnt = m1.vld;
    end
  end

  // Request multiplexer driven by the grant.
  always_comb begin
    w_vld = w_gnt ? m1.vld : m0.vld;
    w_wen = w_gnt ? m1.wen : m0.wen;
    w_adr = w_gnt ? m1.adr : m0.adr;
    w_ben = w_gnt ? m1.ben : m0.ben;
    w_wdt = w_gnt ? m1.wdt : m0.wdt;
  end

  assign s.vld  = w_vld & ~rst;
  assign s.wen  = w_wen;
  assign s.adr  = w_adr;
  assign s.ben  = w_ben;
  assign s.wdt  = w_wdt;

  assign m0.rdy = ~w_gnt & s.rdy & ~rst;
  assign m1.rdy =  w_gnt & s.rdy & ~rst;

  assign w_xfer = s.vld & s.rdy;

  // Lock FSM: capture the grant when the subordinate stalls, release on transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FREE;
      r_lgnt  <= 1'b0;
    end else begin
      case (r_state)
        ST_FREE: begin
          if (s.vld && !s.rdy) begin
            r_state <= ST_LOCK;
            r_lgnt  <= w_gnt;
          end
        end
        ST_LOCK: begin
          if (s.vld && s.rdy) r_state <= ST_FREE;
        end
        default: r_state <= ST_FREE;
      endcase
    end
  end

  // Starvation counter: LSU transfers while IFU waits, cleared by an IFU transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt <= 4'd0;
    end else if (w_xfer && !w_gnt) begin
      r_scnt <= 4'd0;
    end else if (w_xfer && w_gnt && m0.vld && (r_scnt != STV_C)) begin
      r_scnt <= r_scnt + 4'd1;
    end
  end

  assign w_tag_in.vld = w_xfer;
  assign w_tag_in.id  = w_gnt;

  r5p_tcb_arb_rte #(
    .DLY (DLY)
  ) u_rte (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_own)
  );

  // Read data is broadcast; only the owner of a valid tag sees the error.
  assign m0.rdt = s.rdt;
  assign m1.rdt = s.rdt;
  assign m0.err = s.err & w_own.vld & ~w_own.id[0] & ~rst;
  assign m1.err = s.err & w_own.vld &  w_own.id[0] & ~rst;

  assign o_lck  = (r_state == ST_LOCK);
  assign o_lgnt = r_lgnt;
  assign o_scnt = r_scnt;

endmodule

// File: tb/tb_r5p_tcb_arb2.sv
// Directed bench for r5p_tcb_arb2: three instances with DLY = 1, 2 and 0.
module tb_r5p_tcb_arb2;

  logic clk;
  logic rst;

  int n_chk  = 0;
  int n_pass = 0;

  logic [0:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- interfaces and instances ----------------
  r5p_tcb_arb2_if a1_m0 ();
  r5p_tcb_arb2_if a1_m1 ();
  r5p_tcb_arb2_if a1_s  ();
  r5p_tcb_arb2_if a2_m0 ();
  r5p_tcb_arb2_if a2_m1 ();
  r5p_tcb_arb2_if a2_s  ();
  r5p_tcb_arb2_if a0_m0 ();
  r5p_tcb_arb2_if a0_m1 ();
  r5p_tcb_arb2_if a0_s  ();

  logic       d1_lck, d2_lck, d0_lck;
  logic       d1_lgnt, d2_lgnt, d0_lgnt;
  logic [3:0] d1_scnt, d2_scnt, d0_scnt;

  r5p_tcb_arb2 #(.DLY(1), .STV(4)) u_dut1 (
    .clk (clk), .rst (rst), .m0 (a1_m0), .m1 (a1_m1), .s (a1_s),
    .o_lck (d1_lck), .o_lgnt (d1_lgnt), .o_scnt (d1_scnt)
  );

  r5p_tcb_arb2 #(.DLY(2), .STV(4)) u_dut2 (
    .clk (clk), .rst (rst), .m0 (a2_m0), .m1 (a2_m1), .s (a2_s),
    .o_lck (d2_lck), .o_lgnt (d2_lgnt), .o_scnt (d2_scnt)
  );

  r5p_tcb_arb2 #(.DLY(0), .STV(4)) u_dut0 (
    .clk (clk), .rst (rst), .m0 (a0_m0), .m1 (a0_m1), .s (a0_s),
    .o_lck (d0_lck), .o_lgnt (d0_lgnt), .o_scnt (d0_scnt)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic idle_all();
    {a1_m0.vld, a1_m0.wen, a1_m0.adr, a1_m0.ben, a1_m0.wdt} = '0;
    {a1_m1.vld, a1_m1.wen, a1_m1.adr, a1_m1.ben, a1_m1.wdt} = '0;
    {a1_s.rdy, a1_s.rdt, a1_s.err} = '0;
    {a2_m0.vld, a2_m0.wen, a2_m0.adr, a2_m0.ben, a2_m0.wdt} = '0;
    {a2_m1.vld, a2_m1.wen, a2_m1.adr, a2_m1.ben, a2_m1.wdt} = '0;
    {a2_s.rdy, a2_s.rdt, a2_s.err} = '0;
    {a0_m0.vld, a0_m0.wen, a0_m0.adr, a0_m0.ben, a0_m0.wdt} = '0;
    {a0_m1.vld, a0_m1.wen, a0_m1.adr, a0_m1.ben, a0_m1.wdt} = '0;
    {a0_s.rdy, a0_s.rdt, a0_s.err} = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int gseq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [0:0] g_exp;

    // Reset with requests present: nothing may leak to the subordinate.
    rst = 1'b1;
    idle_all();
    a1_m0.vld = 1'b1;
    a1_s.rdy  = 1'b1;
    tick();
    probe();
    check("rst_s_vld",  a1_s.vld,  1'b0);
    check("rst_m0_rdy", a1_m0.rdy, 1'b0);
    check("rst_lck",    d1_lck,    1'b0);
    check("rst_scnt",   d1_scnt,   4'd0);
    tick();
    rst = 1'b0;

    // Single IFU read, DLY=1: grant in cycle 0, data in cycle 1.
    idle_all();
    a1_m0.vld = 1'b1;
    a1_m0.adr = 32'h100;
    a1_s.rdy  = 1'b1;
    probe();
    check("ifu_m0_rdy", a1_m0.rdy, 1'b1);
    check("ifu_m1_rdy", a1_m1.rdy, 1'b0);
    check("ifu_s_vld",  a1_s.vld,  1'b1);
    check("ifu_s_adr",  a1_s.adr,  32'h100);
    tick();
    a1_m0.vld = 1'b0;
    a1_s.rdt  = 32'hDEADBEEF;
    a1_s.err  = 1'b1;
    probe();
    check("ifu_m0_rdt", a1_m0.rdt, 32'hDEADBEEF);
    check("ifu_m0_err", a1_m0.err, 1'b1);
    check("ifu_m1_err", a1_m1.err, 1'b0);
    check("ifu_s_vld1", a1_s.vld,  1'b0);
    tick();

    // Contention, STV=4: LSU x4 then one IFU, repeated.
    idle_all();
    foreach (gseq[i]) exp_q.push_back(1'(gseq[i]));
    a1_m0.vld = 1'b1;
    a1_m0.adr = 32'h200;
    a1_m1.vld = 1'b1;
    a1_m1.adr = 32'h300;
    a1_s.rdy  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      probe();
      g_exp = exp_q.pop_front();
      check("cont_gnt",    a1_m1.rdy, g_exp);
      check("cont_onehot", a1_m0.rdy ^ a1_m1.rdy, 1'b1);
      check("cont_adr",    a1_s.adr, g_exp ? 32'h300 : 32'h200);
      check("cont_scnt_le_stv", d1_scnt <= 4'd4, 1'b1);
      tick();
    end
    check("cont_scnt_end", d1_scnt, 4'd0);

    // Lock: IFU stalled for 3 cycles, LSU arrives in cycle 1 and must wait.
    idle_all();
    a1_m0.vld = 1'b1;
    a1_m0.adr = 32'h400;
    probe();
    check("lck_c0_adr",    a1_s.adr,  32'h400);
    check("lck_c0_m0_rdy", a1_m0.rdy, 1'b0);
    tick();
    a1_m1.vld = 1'b1;
    a1_m1.adr = 32'h500;
    for (int c = 1; c < 3; c++) begin
      probe();
      check("lck_hold_adr",    a1_s.adr,  32'h400);
      check("lck_hold_m1_rdy", a1_m1.rdy, 1'b0);
      check("lck_hold_lck",    d1_lck,    1'b1);
      check("lck_hold_lgnt",   d1_lgnt,   1'b0);
      tick();
    end
    a1_s.rdy = 1'b1;
    probe();
    check("lck_c3_adr",    a1_s.adr,  32'h400);
    check("lck_c3_m0_rdy", a1_m0.rdy, 1'b1);
    check("lck_c3_m1_rdy", a1_m1.rdy, 1'b0);
    tick();
    a1_m0.vld = 1'b0;
    probe();
    check("lck_c4_adr",    a1_s.adr,  32'h500);
    check("lck_c4_m1_rdy", a1_m1.rdy, 1'b1);
    check("lck_c4_lck",    d1_lck,    1'b0);
    tick();

    // Reset while the LSU holds the lock.
    idle_all();
    a1_m0.vld = 1'b1;
    a1_m0.adr = 32'h600;
    a1_m1.vld = 1'b1;
    a1_m1.adr = 32'h680;
    probe();
    check("rlk_c0_adr", a1_s.adr, 32'h680);
    tick();
    rst = 1'b1;
    a1_s.rdy = 1'b1;
    probe();
    check("rlk_c1_lck",    d1_lck,    1'b1);
    check("rlk_c1_lgnt",   d1_lgnt,   1'b1);
    check("rlk_c1_s_vld",  a1_s.vld,  1'b0);
    check("rlk_c1_m1_rdy", a1_m1.rdy, 1'b0);
    tick();
    rst = 1'b0;
    a1_m0.vld = 1'b0;
    a1_m1.vld = 1'b0;
    a1_s.err  = 1'b1;
    probe();
    check("rlk_c2_lck",    d1_lck,    1'b0);
    check("rlk_c2_lgnt",   d1_lgnt,   1'b0);
    check("rlk_c2_s_vld",  a1_s.vld,  1'b0);
    check("rlk_c2_m0_err", a1_m0.err, 1'b0);
    check("rlk_c2_m1_err", a1_m1.err, 1'b0);
    tick();
    a1_s.err  = 1'b0;
    a1_m0.vld = 1'b1;
    a1_m0.adr = 32'h700;
    a1_m1.vld = 1'b1;
    a1_m1.adr = 32'h800;
    probe();
    check("rlk_c3_m1_rdy", a1_m1.rdy, 1'b1);
    check("rlk_c3_adr",    a1_s.adr,  32'h800);
    tick();
    idle_all();

    // Alternating routing, DLY=2: IFU, LSU, IFU in consecutive cycles.
    a2_s.rdy  = 1'b1;
    a2_m0.vld = 1'b1;
    a2_m0.adr = 32'h10;
    probe();
    check("alt_c0_m0_rdy", a2_m0.rdy, 1'b1);
    tick();
    a2_m0.vld = 1'b0;
    a2_m1.vld = 1'b1;
    a2_m1.adr = 32'h20;
    probe();
    check("alt_c1_m1_rdy", a2_m1.rdy, 1'b1);
    check("alt_c1_adr",    a2_s.adr,  32'h20);
    tick();
    a2_m1.vld = 1'b0;
    a2_m0.vld = 1'b1;
    a2_m0.adr = 32'h30;
    a2_s.rdt  = 32'h1;
    probe();
    check("alt_c2_m0_rdt", a2_m0.rdt, 32'h1);
    check("alt_c2_m0_rdy", a2_m0.rdy, 1'b1);
    tick();
    a2_m0.vld = 1'b0;
    a2_s.rdt  = 32'h2;
    a2_s.err  = 1'b1;
    probe();
    check("alt_c3_m1_rdt", a2_m1.rdt, 32'h2);
    check("alt_c3_m1_err", a2_m1.err, 1'b1);
    check("alt_c3_m0_err", a2_m0.err, 1'b0);
    tick();
    a2_s.rdt = 32'h3;
    a2_s.err = 1'b1;
    probe();
    check("alt_c4_m0_rdt", a2_m0.rdt, 32'h3);
    check("alt_c4_m0_err", a2_m0.err, 1'b1);
    check("alt_c4_m1_err", a2_m1.err, 1'b0);
    tick();
    probe();
    check("alt_c5_m0_err", a2_m0.err, 1'b0);
    check("alt_c5_m1_err", a2_m1.err, 1'b0);
    tick();
    idle_all();

    // DLY=0: LSU write with a combinational error response.
    a0_s.rdy  = 1'b1;
    a0_s.err  = 1'b1;
    a0_m1.vld = 1'b1;
    a0_m1.wen = 1'b1;
    a0_m1.adr = 32'h40;
    a0_m1.ben = 4'b0011;
    a0_m1.wdt = 32'hCAFE0001;
    probe();
    check("d0_s_wen",  a0_s.wen,  1'b1);
    check("d0_s_ben",  a0_s.ben,  4'b0011);
    check("d0_s_wdt",  a0_s.wdt,  32'hCAFE0001);
    check("d0_m1_rdy", a0_m1.rdy, 1'b1);
    check("d0_m1_err", a0_m1.err, 1'b1);
    check("d0_m0_err", a0_m0.err, 1'b0);
    tick();
    a0_m1.vld = 1'b0;
    probe();
    check("d0_idle_m1_err", a0_m1.err, 1'b0);
    tick();
    idle_all();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/r5p_tcb_arb2.md
Name: r5p_tcb_arb2

Overview:
- Two-manager to one-subordinate TCB arbiter. Merges the Degu instruction-fetch bus (IFU) and the load/store bus (LSU) onto a single unified memory port, for single-port SRAM or external-bus builds.
- Fixed LSU priority, bounded IFU starvation, grant locking while the subordinate stalls.
- Response routing over a DLY-deep pipeline of grant tags.

Parameters:
- AW, 32, address width
- DW, 32, data width
- BW, DW/8, byte-enable width
- DLY, 1, subordinate response delay in cycles after transfer (0..4); 0 = combinational response
- STV, 4, maximum consecutive LSU transfers while an IFU request waits (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m0_vld  in  1  IFU request valid (index 0)
- m0_wen  in  1  IFU write enable
- m0_adr  in  AW  IFU address
- m0_ben  in  BW  IFU byte enables
- m0_wdt  in  DW  IFU write data
- m0_rdy  out  1  IFU ready
- m0_rdt  out  DW  IFU read data
- m0_err  out  1  IFU error
- m1_vld, m1_wen, m1_adr, m1_ben, m1_wdt, m1_rdy, m1_rdt, m1_err: same as m0_*, for LSU (index 1)
- s_vld  out  1  subordinate request valid
- s_wen  out  1  subordinate write enable
- s_adr  out  AW  subordinate address
- s_ben  out  BW  subordinate byte enables
- s_wdt  out  DW  subordinate write data
- s_rdy  in  1  subordinate ready
- s_rdt  in  DW  subordinate read data
- s_err  in  1  subordinate error

Behaviour:
- Transfer on a port = vld & rdy in the same cycle.
- Managers hold vld and request fields stable until their transfer.

Grant selection (combinational from registered state):
- If lck=1, grant = lgnt.
- Else if m0_vld & m1_vld: grant = 0 when scnt==STV, otherwise grant = 1.
- Else grant = whichever manager is valid; 0 if none.

Request path:
- s_vld = m{grant}_vld & ~rst.
- s_wen/adr/ben/wdt = fields of the granted manager.
- m{grant}_rdy = s_rdy & ~rst; the other manager's rdy = 0.

Lock (lck, lgnt):
- Set lck=1 and lgnt=grant when s_vld & ~s_rdy.
- Clear lck on s_vld & s_rdy.
- The manager holding the lock is never preempted; the starvation override applies only when lck=0.

Starvation counter (scnt, 4 bits):
- On an LSU transfer while m0_vld=1: increment, saturating at STV.
- On an IFU transfer: clear to 0.
- Otherwise hold.

Response routing:
- Shift register rte[DLY-1:0] of {valid, id}; each entry is loaded with {transfer, grant} on every cycle.
- Response owner = entry DLY-1.
- m{id}_rdt = s_rdt; m{id}_err = s_err & valid.
- The non-owner receives rdt = s_rdt (don't-care) and err = 0.
- DLY=0: owner = current grant, valid = transfer.

Back-to-back:
- Transfers may issue every cycle and alternate owners.
- Routing remains correct because tags are pipelined, not shared.

Simultaneous requests:
- LSU wins until scnt==STV; then exactly one IFU transfer is granted and scnt is cleared.

Reset:
- Mid-operation reset: lck=0, lgnt=0, scnt=0, all rte valid bits = 0, all rdy=0, s_vld=0, err=0.
- In-flight responses are discarded.
- First grant is possible on the first cycle after rst deasserts.

No-request cycle:
- s_vld=0, scnt holds, rte is loaded with invalid entries.

Decomposition:
- Add to tcb_pkg: localparam TCB_ARB_MAN=2, and typedef tcb_arb_tag_t (struct: vld, id[0:0]).
- One sub-module, r5p_tcb_arb_rte: the DLY-deep tag pipeline with a DLY=0 bypass generate branch.
- Grant, lock and counter logic stay in the top module.

Test Plan:
- Single IFU read: m0_vld=1, adr=0x100, s_rdy=1, DLY=1, s_rdt=0xDEADBEEF the next cycle -> m0_rdy=1 in cycle 0; m0_rdt=0xDEADBEEF in cycle 1; m1_err=0.
- Contention, STV=4: both valid continuously, s_rdy=1 -> grant sequence 1,1,1,1,0,1,1,1,1,0; scnt never exceeds 4.
- Lock: IFU granted, s_rdy=0 for 3 cycles, m1_vld rises in cycle 1 -> s_adr stays at the IFU address; m1_rdy=0 until the IFU transfer; LSU is granted the following cycle.
- Alternating routing, DLY=2: transfers IFU, LSU, IFU in consecutive cycles, s_rdt=0x1,0x2,0x3 in cycles 2-4 -> m0 gets 0x1 and 0x3, m1 gets 0x2; s_err=1 in cycle 3 is seen only on m1_err.
- Reset mid-lock: s_rdy=0 with lock held, rst=1 for one cycle -> lck=0, s_vld=0, no response is delivered for the aborted tag; normal arbitration resumes after rst deasserts.
- DLY=0: LSU write, wen=1, ben=4'b0011, s_err=1 combinational -> m1_err=1 in the same cycle; m0_err=0.
